decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_pkg.sv | 17 +
 rtl/decode_stage_grf.sv | 38 +++
 rtl/decode_stage.sv | 110 +++++++++++
 3 files changed

// File: rtl/decode_stage_pkg.sv
// Opcode/funct constants and fetch-select encodings shared by decode and fetch.
// Only the instructions decode acts on are named here; everything else decodes as "other".
package decode_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] PCSEL_PC4 = 2'b00;
  localparam logic [1:0] PCSEL_NPC = 2'b01;

endpackage

// File: rtl/decode_stage_grf.sv
// 32x32 register file, two combinational reads, one write on posedge, async clear.
// With GRF_BYPASS_EN defined a same-cycle write is forwarded to the read ports.
module grf (
  input  logic        clk,
  input  logic        Reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] regs [32];

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      regs <= '{default: '0};
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

`ifdef GRF_BYPASS_EN
  // Forwarding is suppressed under reset so a discarded write never becomes visible.
  logic fwd1, fwd2;
  assign fwd1 = we && !Reset && (waddr == raddr1);
  assign fwd2 = we && !Reset && (waddr == raddr2);

  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : (fwd1 ? wdata : regs[raddr1]);
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : (fwd2 ? wdata : regs[raddr2]);
`else
  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];
`endif

endmodule

// File: rtl/decode_stage.sv
// ID stage: register read, immediate extend, branch/jump redirect (comb) and ID/EX register (1 cycle).
// stall loads a bubble into ID/EX; GRF_BYPASS_EN selects write-through reads in the grf.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter logic [31:0] PC_BASE = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [31:0] D_instr,
  input  logic [31:0] D_PC,
  input  logic        stall,
  input  logic        W_we,
  input  logic [4:0]  W_waddr,
  input  logic [31:0] W_wdata,
  output logic [31:0] next_pc,
  output logic [1:0]  PCSel,
  output logic [31:0] E_instr_reg,
  output logic [31:0] E_PC_reg,
  output logic [31:0] E_rs_data_reg,
  output logic [31:0] E_rt_data_reg,
  output logic [31:0] E_imm_ext_reg
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [15:0] imm;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] imm_ext;
  logic [31:0] pc4;
  logic [31:0] br_target;

  assign opcode = D_instr[31:26];
  assign rs     = D_instr[25:21];
  assign rt     = D_instr[20:16];
  assign imm    = D_instr[15:0];
  assign funct  = D_instr[5:0];

  grf u_grf (
    .clk    (clk),
    .Reset  (Reset),
    .we     (W_we),
    .waddr  (W_waddr),
    .wdata  (W_wdata),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rs_data),
    .rdata2 (rt_data)
  );

  always_comb begin
    imm_ext = {{16{imm[15]}}, imm};
    if (opcode == OP_ORI) imm_ext = {16'd0, imm};
    else if (opcode == OP_LUI) imm_ext = {imm, 16'd0};
  end

  assign pc4       = D_PC + 32'd4;
  assign br_target = pc4 + {{14{imm[15]}}, imm, 2'b00};

  always_comb begin
    PCSel   = PCSEL_PC4;
    next_pc = pc4;
    case (opcode)
      OP_BEQ: begin
        if (rs_data == rt_data) begin
          PCSel   = PCSEL_NPC;
          next_pc = br_target;
        end
      end
      OP_J, OP_JAL: begin
        PCSel   = PCSEL_NPC;
        next_pc = {pc4[31:28], D_instr[25:0], 2'b00};
      end
      OP_RTYPE: begin
        if (funct == FN_JR) begin
          PCSel   = PCSEL_NPC;
          next_pc = rs_data;
        end
      end
      default: ;
    endcase
  end

  // Reset and bubble share the same ID/EX image: zero instruction at PC_BASE.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      E_instr_reg   <= 32'd0;
      E_PC_reg      <= PC_BASE;
      E_rs_data_reg <= 32'd0;
      E_rt_data_reg <= 32'd0;
      E_imm_ext_reg <= 32'd0;
    end else if (stall) begin
      E_instr_reg   <= 32'd0;
      E_PC_reg      <= PC_BASE;
      E_rs_data_reg <= 32'd0;
      E_rt_data_reg <= 32'd0;
      E_imm_ext_reg <= 32'd0;
    end else begin
      E_instr_reg   <= D_instr;
      E_PC_reg      <= D_PC;
      E_rs_data_reg <= rs_data;
      E_rt_data_reg <= rt_data;
      E_imm_ext_reg <= imm_ext;
    end
  end

endmodule
